// File: rtl/s27_bist_ctrl.sv
// s27_bist_ctrl: BIST sequencer for the s27 core.
// It flushes the core's state flops, applies LFSR patterns on G0..G3, folds
// G17 into a 16-bit MISR, and checks the final signature against a golden value.
module s27_bist_ctrl #(
    parameter int          NUM_PATTERNS = 64,
    parameter int          FLUSH_CYCLES = 3,
    parameter logic [3:0]  FLUSH_VEC    = 4'b0100,
    parameter logic [3:0]  LFSR_SEED    = 4'b0001,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0E1F
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    output logic [3:0]  o_dut_pi,
    input  logic        i_dut_g17,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_signature
);

    localparam int CNT_MAX = (NUM_PATTERNS > FLUSH_CYCLES) ? NUM_PATTERNS : FLUSH_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST   = CW'(NUM_PATTERNS - 1);
    // An all-zero seed would lock the LFSR, so fall back to 0001.
    localparam logic [3:0]    SEED       = (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;
    localparam logic [15:0]   MISR_POLY  = 16'h1021;
    localparam logic [15:0]   MISR_INIT  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [CW-1:0]  r_cnt;
    logic [3:0]     r_lfsr;
    logic [3:0]     r_dut_pi;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [15:0]    r_sig;

    // Control strobes decoded from the FSM for the datapath.
    logic           w_go;
    logic           w_flush_step;
    logic           w_flush_end;
    logic           w_absorb;
    logic           w_run_end;
    logic           w_stop;
    logic           w_latch;

    logic [3:0]     w_lfsr_nxt;
    logic           w_fb;
    logic [15:0]    w_misr_nxt;

    // x^4+x^3+1 LFSR step and CRC-CCITT style MISR step.
    always_comb begin
        w_lfsr_nxt = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
        w_fb       = r_sig[15] ^ i_dut_g17;
        w_misr_nxt = {r_sig[14:0], 1'b0} ^ (w_fb ? MISR_POLY : 16'h0000);
    end

    // State register; reset wins over every other input.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and strobe decode; abort only matters while a test is active.
    always_comb begin
        w_state_nxt  = r_state;
        w_go         = 1'b0;
        w_flush_step = 1'b0;
        w_flush_end  = 1'b0;
        w_absorb     = 1'b0;
        w_run_end    = 1'b0;
        w_stop       = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FLUSH;
                    w_go        = 1'b1;
                end
            end
            S_FLUSH: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_stop      = 1'b1;
                end else if (r_cnt == FLUSH_LAST) begin
                    w_state_nxt = S_RUN;
                    w_flush_end = 1'b1;
                end else begin
                    w_flush_step = 1'b1;
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_stop      = 1'b1;
                end else begin
                    w_absorb = 1'b1;
                    if (r_cnt == RUN_LAST) begin
                        w_state_nxt = S_DONE;
                        w_run_end   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_latch     = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: pattern register, counter, LFSR, MISR and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_lfsr   <= 4'b0000;
            r_dut_pi <= 4'b0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_sig    <= MISR_INIT;
        end else begin
            r_done <= 1'b0;
            if (w_go) begin
                r_dut_pi <= FLUSH_VEC;
                r_cnt    <= '0;
                r_sig    <= MISR_INIT;
                r_pass   <= 1'b0;
                r_busy   <= 1'b1;
            end
            if (w_flush_step) r_cnt <= r_cnt + CW'(1);
            if (w_flush_end) begin
                r_dut_pi <= SEED;
                r_lfsr   <= SEED;
                r_cnt    <= '0;
            end
            if (w_absorb) begin
                r_sig    <= w_misr_nxt;
                r_lfsr   <= w_lfsr_nxt;
                r_dut_pi <= w_lfsr_nxt;
                r_cnt    <= r_cnt + CW'(1);
            end
            // Final pattern absorbed: park the core inputs.
            if (w_run_end || w_stop) begin
                r_dut_pi <= 4'b0000;
                r_busy   <= 1'b0;
            end
            if (w_latch) begin
                r_done <= 1'b1;
                r_pass <= (r_sig == GOLDEN_SIG);
            end
        end
    end

    assign o_dut_pi    = r_dut_pi;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_signature = r_sig;

endmodule
